// File: rtl/controller_op_stack.sv
// Operator stack for infix-to-postfix conversion: parks incoming operators by precedence and
// streams them to the ALU sequencer in evaluation order, with paren and overflow checking.
module controller_op_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CO_N  = 3,
    parameter int unsigned IC_N  = 5
) (
    input  logic                       clk,
    input  logic                       Reset,
    input  logic                       in_valid,
    input  logic [IC_N-1:0]            in_cmd,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [CO_N-1:0]            out_op,
    input  logic                       out_ready,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [CO_N-1:0]            top_op
);
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [IC_N-1:0] IC_OPAD = IC_N'(1);
    localparam logic [IC_N-1:0] IC_OPSB = IC_N'(2);
    localparam logic [IC_N-1:0] IC_OPMU = IC_N'(3);
    localparam logic [IC_N-1:0] IC_OPDI = IC_N'(4);
    localparam logic [IC_N-1:0] IC_EXLP = IC_N'(5);
    localparam logic [IC_N-1:0] IC_EXRP = IC_N'(6);
    localparam logic [IC_N-1:0] IC_CTOK = IC_N'(7);

    localparam logic [CO_N-1:0] CO_NO = CO_N'(0);
    localparam logic [CO_N-1:0] CO_AD = CO_N'(1);
    localparam logic [CO_N-1:0] CO_SB = CO_N'(2);
    localparam logic [CO_N-1:0] CO_MU = CO_N'(3);
    localparam logic [CO_N-1:0] CO_DI = CO_N'(4);
    localparam logic [CO_N-1:0] CO_LP = CO_N'(5);
    localparam logic [CO_N-1:0] CO_RP = CO_N'(6);
    localparam logic [CO_N-1:0] CO_OK = CO_N'(7);

    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_RP  = 2'd2;
    localparam logic [1:0] ERR_LP  = 2'd3;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReduce, StErr} state_e;

    function automatic logic [CO_N-1:0] decode_cmd(input logic [IC_N-1:0] c);
        case (c)
            IC_OPAD: return CO_AD;
            IC_OPSB: return CO_SB;
            IC_OPMU: return CO_MU;
            IC_OPDI: return CO_DI;
            IC_EXLP: return CO_LP;
            IC_EXRP: return CO_RP;
            IC_CTOK: return CO_OK;
            default: return CO_NO;
        endcase
    endfunction

    function automatic logic [1:0] prec(input logic [CO_N-1:0] op);
        if (op == CO_MU || op == CO_DI) return 2'd2;
        if (op == CO_AD || op == CO_SB) return 2'd1;
        return 2'd0;
    endfunction

    state_e          state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [CO_N-1:0] pending_q, pending_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [CO_N-1:0] stack_q [DEPTH];
    logic [CO_N-1:0] stack_d [DEPTH];

    logic            empty, full;
    logic [AW-1:0]   top_idx, push_idx;
    logic [CO_N-1:0] top, cmd_op;

    assign empty    = (depth_q == '0);
    assign full     = (depth_q == DEPTH_MAX);
    assign top_idx  = AW'(depth_q - DW'(1));
    assign push_idx = AW'(depth_q);
    assign top      = empty ? CO_NO : stack_q[top_idx];

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q    <= StIdle;
            depth_q    <= '0;
            pending_q  <= CO_NO;
            err_code_q <= 2'd0;
            for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= CO_NO;
        end else begin
            state_q    <= state_d;
            depth_q    <= depth_d;
            pending_q  <= pending_d;
            err_code_q <= err_code_d;
            stack_q    <= stack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        pending_d  = pending_q;
        err_code_d = err_code_q;
        stack_d    = stack_q;
        cmd_op     = decode_cmd(in_cmd);
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cmd_op == CO_LP) begin
                        // Open parens go straight onto the stack; nothing can be reduced by them.
                        if (full) begin
                            state_d    = StErr;
                            err_code_d = ERR_OVF;
                        end else begin
                            stack_d[push_idx] = CO_LP;
                            depth_d           = depth_q + DW'(1);
                        end
                    end else if (cmd_op != CO_NO) begin
                        pending_d = cmd_op;
                        state_d   = StReduce;
                    end
                end
            end

            StReduce: begin
                if (pending_q == CO_RP) begin
                    if (empty) begin
                        state_d    = StErr;
                        err_code_d = ERR_RP;
                    end else if (top == CO_LP) begin
                        depth_d   = depth_q - DW'(1);
                        pending_d = CO_NO;
                        state_d   = StIdle;
                    end else begin
                        out_valid = 1'b1;
                        if (out_ready) depth_d = depth_q - DW'(1);
                    end
                end else if (pending_q == CO_OK) begin
                    if (empty) begin
                        done      = 1'b1;
                        pending_d = CO_NO;
                        state_d   = StIdle;
                    end else if (top == CO_LP) begin
                        state_d    = StErr;
                        err_code_d = ERR_LP;
                    end else begin
                        out_valid = 1'b1;
                        if (out_ready) depth_d = depth_q - DW'(1);
                    end
                end else if (!empty && prec(top) >= prec(pending_q)) begin
                    // LP has precedence 0, so a binary op never reduces past an open paren.
                    out_valid = 1'b1;
                    if (out_ready) depth_d = depth_q - DW'(1);
                end else if (full) begin
                    state_d    = StErr;
                    err_code_d = ERR_OVF;
                end else begin
                    stack_d[push_idx] = pending_q;
                    depth_d           = depth_q + DW'(1);
                    pending_d         = CO_NO;
                    state_d           = StIdle;
                end
            end

            default: ;
        endcase
    end

    assign out_op   = top;
    assign top_op   = top;
    assign depth    = depth_q;
    assign err      = (state_q == StErr);
    assign err_code = err_code_q;

endmodule

// File: tb/tb_controller_op_stack.sv
// Bench for controller_op_stack: directed scenarios plus random command streams checked
// against a queue-based shunting-yard reference model.
module tb_controller_op_stack;
    localparam int unsigned DEPTH = 8;

    localparam logic [4:0] C_AD = 5'd1;
    localparam logic [4:0] C_SB = 5'd2;
    localparam logic [4:0] C_MU = 5'd3;
    localparam logic [4:0] C_DI = 5'd4;
    localparam logic [4:0] C_LP = 5'd5;
    localparam logic [4:0] C_RP = 5'd6;
    localparam logic [4:0] C_OK = 5'd7;

    logic       clk, Reset;
    logic       in_valid, in_ready, out_valid, out_ready, done, err;
    logic [4:0] in_cmd;
    logic [2:0] out_op, top_op;
    logic [1:0] err_code;
    logic [3:0] depth;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_done, s_err;
    logic [4:0] s_in_cmd;
    logic [2:0] s_out_op, s_top_op;
    logic [1:0] s_err_code;
    logic [1:0] s_depth;

    int n_checks = 0;
    int n_fail   = 0;
    int got[$];
    int done_cnt;
    bit acc;
    bit rand_ready;

    int cmd_q[$];
    int exp_ops[$];
    int exp_done, exp_code, exp_depth, exp_top;

    controller_op_stack #(.DEPTH(DEPTH), .CO_N(3), .IC_N(5)) dut (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_cmd(in_cmd), .in_ready(in_ready),
        .out_valid(out_valid), .out_op(out_op), .out_ready(out_ready), .done(done), .err(err),
        .err_code(err_code), .depth(depth), .top_op(top_op)
    );

    controller_op_stack #(.DEPTH(2), .CO_N(3), .IC_N(5)) dut_small (
        .clk(clk), .Reset(Reset), .in_valid(s_in_valid), .in_cmd(s_in_cmd),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_op(s_out_op),
        .out_ready(s_out_ready), .done(s_done), .err(s_err), .err_code(s_err_code),
        .depth(s_depth), .top_op(s_top_op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // One clock: sample handshakes 1ns after inputs settle, then advance to the next negedge.
    task automatic tick();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        acc = in_valid && in_ready && Reset;
        if (Reset && out_valid && out_ready) got.push_back(int'(out_op));
        if (Reset && done) done_cnt++;
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] cmd);
        int n = 0;
        in_valid = 1'b1;
        in_cmd   = cmd;
        acc      = 1'b0;
        while (!acc && !err && n < 200) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc && !err) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout cmd=%0d not accepted within 200 cycles", cmd);
        end
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while (!(in_ready && !out_valid) && !err && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout in_ready=%0b out_valid=%0b", in_ready, out_valid);
        end
    endtask

    task automatic do_reset();
        Reset      = 1'b0;
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        out_ready  = 1'b0;
        rand_ready = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        got.delete();
        done_cnt = 0;
    endtask

    function automatic int op_of(input int c);
        case (c)
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 4;
            5: return 5;
            6: return 6;
            7: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int prec(input int op);
        if (op == 3 || op == 4) return 2;
        if (op == 1 || op == 2) return 1;
        return 0;
    endfunction

    // Classic shunting-yard over a queue stack; stops at the first error like the hardware.
    task automatic model();
        int st[$];
        int op;
        bit stop = 1'b0;
        exp_ops.delete();
        exp_done = 0;
        exp_code = 0;
        for (int i = 0; i < cmd_q.size() && !stop; i++) begin
            op = op_of(cmd_q[i]);
            if (op == 5) begin
                if (st.size() == DEPTH) begin exp_code = 1; stop = 1'b1; end
                else st.push_back(op);
            end else if (op >= 1 && op <= 4) begin
                while (st.size() > 0 && prec(st[$]) >= prec(op)) exp_ops.push_back(st.pop_back());
                if (st.size() == DEPTH) begin exp_code = 1; stop = 1'b1; end
                else st.push_back(op);
            end else if (op == 6) begin
                while (1) begin
                    if (st.size() == 0) begin exp_code = 2; stop = 1'b1; break; end
                    if (st[$] == 5) begin void'(st.pop_back()); break; end
                    exp_ops.push_back(st.pop_back());
                end
            end else if (op == 7) begin
                while (st.size() > 0 && st[$] != 5) exp_ops.push_back(st.pop_back());
                if (st.size() > 0) begin exp_code = 3; stop = 1'b1; end
                else exp_done++;
            end
        end
        exp_depth = st.size();
        exp_top   = (st.size() > 0) ? st[$] : 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL reset_depth got=%0d exp=0", depth); end
        n_checks++; if (top_op !== 3'd0) begin n_fail++; $display("FAIL reset_top_op got=%0d exp=0", top_op); end
        n_checks++; if (err !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL reset_err got=%0b/%0d exp=0/0", err, err_code); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    endtask

    task automatic test_latency();
        do_reset();
        out_ready = 1'b1;
        send(C_SB);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || depth !== 4'd0) begin
            n_fail++; $display("FAIL latency_reduce in_ready=%0b out_valid=%0b depth=%0d exp 0/0/0", in_ready, out_valid, depth); end
        tick();
        n_checks++; if (in_ready !== 1'b1 || depth !== 4'd1 || top_op !== 3'd2) begin
            n_fail++; $display("FAIL latency_push in_ready=%0b depth=%0d top=%0d exp 1/1/2", in_ready, depth, top_op); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        send(C_AD);
        send(C_MU);
        send(C_OK);
        drain();
        n_checks++; if (got.size() != 2 || got[0] != 3 || got[1] != 1) begin
            n_fail++; $display("FAIL basic_stream got=%p exp='{3,1}", got); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
        n_checks++; if (depth !== 4'd0) begin n_fail++; $display("FAIL basic_depth got=%0d exp=0", depth); end
    endtask

    task automatic test_hold();
        do_reset();
        out_ready = 1'b0;
        send(C_MU);
        send(C_AD);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_op !== 3'd3) begin
                n_fail++; $display("FAIL hold_%0d out_valid=%0b out_op=%0d exp 1/3", i, out_valid, out_op); end
        end
        out_ready = 1'b1;
        drain();
        n_checks++; if (got.size() != 1 || got[0] != 3) begin n_fail++; $display("FAIL hold_stream got=%p exp='{3}", got); end
        n_checks++; if (depth !== 4'd1 || top_op !== 3'd1) begin
            n_fail++; $display("FAIL hold_final depth=%0d top=%0d exp 1/1", depth, top_op); end
    endtask

    task automatic test_paren();
        do_reset();
        out_ready = 1'b1;
        send(C_LP);
        n_checks++; if (depth !== 4'd1 || top_op !== 3'd5 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL paren_lp depth=%0d top=%0d in_ready=%0b exp 1/5/1", depth, top_op, in_ready); end
        send(C_AD);
        send(C_RP);
        drain();
        n_checks++; if (got.size() != 1 || got[0] != 1) begin n_fail++; $display("FAIL paren_stream got=%p exp='{1}", got); end
        n_checks++; if (depth !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL paren_final depth=%0d in_ready=%0b exp 0/1", depth, in_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        s_in_valid = 1'b1;
        s_in_cmd   = C_LP;
        tick();
        tick();
        tick();
        s_in_valid = 1'b0;
        tick();
        n_checks++; if (s_err !== 1'b1 || s_err_code !== 2'd1) begin
            n_fail++; $display("FAIL ovf_err err=%0b code=%0d exp 1/1", s_err, s_err_code); end
        n_checks++; if (s_depth !== 2'd2 || s_top_op !== 3'd5) begin
            n_fail++; $display("FAIL ovf_stack depth=%0d top=%0d exp 2/5", s_depth, s_top_op); end
        n_checks++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_hs in_ready=%0b out_valid=%0b exp 0/0", s_in_ready, s_out_valid); end
        do_reset();
        n_checks++; if (s_err !== 1'b0 || s_err_code !== 2'd0 || s_depth !== 2'd0 || s_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL ovf_reset err=%0b code=%0d depth=%0d in_ready=%0b exp 0/0/0/1",
                               s_err, s_err_code, s_depth, s_in_ready); end
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 1'b1;
        send(C_RP);
        tick();
        n_checks++; if (err !== 1'b1 || err_code !== 2'd2 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL err_rp err=%0b code=%0d in_ready=%0b exp 1/2/0", err, err_code, in_ready); end
        do_reset();
        out_ready = 1'b1;
        send(C_LP);
        send(C_OK);
        tick();
        tick();
        n_checks++; if (err !== 1'b1 || err_code !== 2'd3 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL err_lp err=%0b code=%0d out_valid=%0b exp 1/3/0", err, err_code, out_valid); end
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL err_lp_done got=%0d exp=0", done_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send(C_MU);
        send(C_AD);
        Reset     = 1'b0;
        in_valid  = 1'b1;
        in_cmd    = C_LP;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || depth !== 4'd0 || top_op !== 3'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midreset out_valid=%0b depth=%0d top=%0d err=%0b exp 0/0/0/0",
                               out_valid, depth, top_op, err); end
        Reset = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int open;
        int len;
        int r;
        bit bad;
        for (int k = 0; k < 40; k++) begin
            do_reset();
            cmd_q.delete();
            open = 0;
            if (k % 8 == 7) cmd_q.push_back(6);
            len = $urandom_range(4, 14);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 9);
                if (r == 4) begin
                    if (open < 3) begin cmd_q.push_back(5); open++; end else cmd_q.push_back(1);
                end else if (r == 5) begin
                    if (open > 0) begin cmd_q.push_back(6); open--; end else cmd_q.push_back(2);
                end else if (r == 6) begin
                    cmd_q.push_back(($urandom_range(0, 1) == 0) ? 0 : 8 + $urandom_range(0, 23));
                end else if (r == 7) begin
                    cmd_q.push_back((open == 0) ? 7 : 3);
                end else begin
                    cmd_q.push_back($urandom_range(1, 4));
                end
            end
            while (open > 0) begin cmd_q.push_back(6); open--; end
            cmd_q.push_back(7);
            model();

            rand_ready = 1'b1;
            for (int i = 0; i < cmd_q.size(); i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(5'(cmd_q[i]));
                if (err) break;
            end
            drain();
            rand_ready = 1'b0;

            bad = (got.size() != exp_ops.size());
            for (int i = 0; i < got.size() && !bad; i++) if (got[i] != exp_ops[i]) bad = 1'b1;
            n_checks++; if (bad) begin n_fail++; $display("FAIL rand%0d_stream got=%p exp=%p", k, got, exp_ops); end
            n_checks++; if (done_cnt != exp_done) begin n_fail++; $display("FAIL rand%0d_done got=%0d exp=%0d", k, done_cnt, exp_done); end
            n_checks++; if (err !== (exp_code != 0) || int'(err_code) != exp_code) begin
                n_fail++; $display("FAIL rand%0d_err err=%0b code=%0d exp_code=%0d", k, err, err_code, exp_code); end
            n_checks++; if (int'(depth) != exp_depth || int'(top_op) != exp_top) begin
                n_fail++; $display("FAIL rand%0d_stack depth=%0d top=%0d exp %0d/%0d", k, depth, top_op, exp_depth, exp_top); end
        end
    endtask

    initial begin
        Reset       = 1'b0;
        in_valid    = 1'b0;
        in_cmd      = 5'd0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_cmd    = 5'd0;
        s_out_ready = 1'b1;
        rand_ready  = 1'b0;
        done_cnt    = 0;
        acc         = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_basic();
        test_hold();
        test_paren();
        test_overflow();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_op_stack.md
CONTROLLER_OP_STACK -- requirements
Module: controller_op_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of operator stack entries (>=2).
REQ-002 SHALL have parameter CO_N, default 3, operator code width (>=3).
REQ-003 SHALL have parameter IC_N, default 5, input command width; command values are the team's IC_* encodings.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port Reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  command offered.
REQ-007 SHALL have port in_cmd  input  IC_N  command code.
REQ-008 SHALL have port in_ready  output  1  command accepted when in_valid&&in_ready at rising edge.
REQ-009 SHALL have port out_valid  output  1  operator offered to ALU sequencer.
REQ-010 SHALL have port out_op  output  CO_N  operator code offered.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_op when out_valid&&out_ready at rising edge.
REQ-012 SHALL have port done  output  1  one-cycle pulse, IC_CTOK evaluation finished.
REQ-013 SHALL have port err  output  1  sticky error.
REQ-014 SHALL have port err_code  output  2  1=overflow, 2=unmatched RP, 3=unmatched LP at OK.
REQ-015 SHALL have port depth  output  clog2(DEPTH+1)  current entry count.
REQ-016 SHALL have port top_op  output  CO_N  top entry; CO_NO when empty.

Function
REQ-017 SHALL decode accepted in_cmd: OPAD->AD=1, OPSB->SB=2, OPMU->MU=3, OPDI->DI=4, EXLP->LP=5, EXRP->RP=6, CTOK->OK=7, any other->NO=0 (accepted, no effect, stay IDLE).
REQ-018 SHALL use precedence MU/DI=2, AD/SB=1, LP=0.
REQ-019 SHALL implement states IDLE, REDUCE, ERR; in_ready=1 only in IDLE.
REQ-020 SHALL latch the decoded op into a pending register on acceptance of AD/SB/MU/DI/RP/OK and enter REDUCE next cycle; LP SHALL be pushed directly in the accept cycle, staying IDLE.
REQ-021 REDUCE, pending binary op: while stack non-empty and prec(top)>=prec(pending), out_valid=1, out_op=top, pop on out_ready; otherwise push pending and return IDLE in that same cycle.
REQ-022 REDUCE, pending RP: emit/pop until top==LP; then pop LP without emitting and return IDLE; empty stack -> ERR, code 2.
REQ-023 REDUCE, pending OK: emit/pop every entry; top==LP -> ERR, code 3; on empty, done=1 for one cycle and return IDLE.
REQ-024 out_valid SHALL be combinational from state and top; out_op SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 At most one pop per cycle; first emission no earlier than the cycle after acceptance.
REQ-026 Push when depth==DEPTH (LP or pending binary op) SHALL enter ERR, code 1, stack unchanged.
REQ-027 In ERR: in_ready=0, out_valid=0, err=1, err_code held, exit only by Reset.
REQ-028 Latency: binary op with no pops accepted at edge N is pushed at edge N+1; in_ready high again at cycle N+1.
REQ-029 depth SHALL never exceed DEPTH nor go below 0.

Reset
REQ-030 Reset low at a rising edge SHALL, mid-operation included, set state IDLE, depth 0, top_op CO_NO, pending NO, err 0, err_code 0, done 0, out_valid 0; in_ready 1 after release.
REQ-031 Reset SHALL take priority over every handshake in the same cycle.

Verification
REQ-032 Reset, then idle -> in_ready=1, out_valid=0, depth=0, top_op=0, err=0.
REQ-033 OPAD, OPMU, CTOK, out_ready=1 -> out_op 3 then 1 on consecutive handshakes, done pulse once, depth=0.
REQ-034 OPMU, OPAD -> MU(3) emitted during AD's REDUCE, then depth=1, top_op=1; out_ready=0 for 3 cycles holds out_valid=1, out_op=3.
REQ-035 EXLP, OPAD, EXRP -> single emission out_op=1, LP discarded, depth=0, in_ready=1.
REQ-036 DEPTH=2: EXLP x3 -> err=1, err_code=1, depth=2, in_ready=0; Reset clears all.
REQ-037 EXRP on empty -> err_code=2; after reset EXLP, CTOK -> err_code=3, done never pulses.
